pcie_ingress_ctrl: RTL

Ingress stage in front of the main FIFO of the PCIe transaction path. Accepts 6-bit words from the traffic source over a valid/ready handshake and buffers them in a small internal queue. Issues registered `push`/`data_out` into the main FIFO only while the main FIFO's `Pausa_MF` is low. Keeps per-VC transmit counters and a stall counter for the bench and the control FSM.

---
 rtl/pcie_ingress_ctrl_if.sv | 33 +++
 rtl/pcie_ingress_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pcie_ingress_ctrl_if.sv
// Ingress-side bus for pcie_ingress_ctrl: source handshake, main-FIFO push path and status.
// The slave modport is the controller's view; master is the source/observer side.
interface pcie_ingress_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 8
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  Pausa_MF;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  tx_count_vc0;
    logic [CNT_WIDTH-1:0]  tx_count_vc1;
    logic [CNT_WIDTH-1:0]  stall_count;
    logic [OCC_W-1:0]      occupancy;

    modport master (
        output in_valid, in_data, Pausa_MF,
        input  in_ready, push, data_out, state, tx_count_vc0, tx_count_vc1, stall_count,
               occupancy
    );

    modport slave (
        input  in_valid, in_data, Pausa_MF,
        output in_ready, push, data_out, state, tx_count_vc0, tx_count_vc1, stall_count,
               occupancy
    );
endinterface

// File: rtl/pcie_ingress_ctrl.sv
// Ingress buffer in front of the PCIe main FIFO: small circular queue, registered push
// gated by Pausa_MF, per-VC transmit counters and a saturating stall counter.
module pcie_ingress_ctrl #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic                clk,
    input logic                reset_L,
    pcie_ingress_ctrl_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned VC_BIT = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StActive = 2'b01,
        StStall  = 2'b10
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OCC_W-1:0]      occ_q;
    logic [OCC_W-1:0]      occ_d;
    logic                  push_q;
    logic [DATA_WIDTH-1:0] data_q;
    state_e                state_q;
    state_e                state_d;
    logic [CNT_WIDTH-1:0]  tx0_q;
    logic [CNT_WIDTH-1:0]  tx1_q;
    logic [CNT_WIDTH-1:0]  stall_q;

    logic                  in_ready;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] head;

    // Both enables look only at registered occupancy, so a word written at an edge
    // cannot also be popped at that same edge.
    assign in_ready = (occ_q < OCC_W'(DEPTH));
    assign wr_en    = bus.in_valid & in_ready;
    assign rd_en    = (occ_q != '0) & ~bus.Pausa_MF;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        occ_d = occ_q;
        unique case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (wr_en) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (bus.Pausa_MF && (occ_d != '0)) begin
                    state_d = StStall;
                end else if ((occ_d == '0) && !rd_en) begin
                    state_d = StIdle;
                end
            end
            StStall: begin
                if (!bus.Pausa_MF) begin
                    state_d = StActive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Queue storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            state_q  <= StIdle;
            tx0_q    <= '0;
            tx1_q    <= '0;
            stall_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            state_q <= state_d;
            push_q  <= rd_en;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                data_q   <= head;
                if (head[VC_BIT]) begin
                    tx1_q <= tx1_q + CNT_WIDTH'(1);
                end else begin
                    tx0_q <= tx0_q + CNT_WIDTH'(1);
                end
            end
            if ((state_d == StStall) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.push         = push_q;
    assign bus.data_out     = data_q;
    assign bus.state        = state_q;
    assign bus.tx_count_vc0 = tx0_q;
    assign bus.tx_count_vc1 = tx1_q;
    assign bus.stall_count  = stall_q;
    assign bus.occupancy    = occ_q;
endmodule
